// File: rtl/dsram_slave_if.sv
// Bus bundle between the core's data bus interface and the data SRAM slave.
// Ports (signals):
//   haddr/hprot/hsize/hwrite/htrans : address phase, driven by master
//   hwdata                          : write data phase, driven by master
//   hrdata/hresp/hready             : data phase response, driven by slave
interface dsram_slave_if;
  logic [31:0] haddr;
  logic        hprot;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        htrans;
  logic [31:0] hrdata;
  logic        hresp;
  logic        hready;

  modport master (
    output haddr, hprot, hsize, hwrite, hwdata, htrans,
    input  hrdata, hresp, hready
  );

  modport slave (
    input  haddr, hprot, hsize, hwrite, hwdata, htrans,
    output hrdata, hresp, hready
  );
endinterface

// File: rtl/dsram_slave.sv
// Single-port data SRAM slave with ahblite-like single-beat transfers.
// Reads return data with zero wait states; writes land at the edge ending the
// write data phase. A read accepted while a write data phase is in progress
// is stalled one cycle (RDW) because the array port is busy with the write.
// Decode/alignment faults get a two-cycle error response (ERR1, ERR2).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dsram_slave_if.slave (address phase in, hwdata in, hrdata/hresp/hready out)
module dsram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  dsram_slave_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {IDLE, RD, WR, RDW, ERR1, ERR2} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rdata_q, rdata_d;

  // No reset on the array; contents survive rst.
  logic [31:0]   mem [DEPTH_WORDS];

  logic          ready;
  logic          fault;
  logic          in_win;
  logic [AW-1:0] idx_a;
  logic [3:0]    be_a;
  logic          unused_hprot;

  // Instruction and data accesses are serviced identically.
  assign unused_hprot = bus.hprot;

  assign ready      = !(state_q == RDW || state_q == ERR1);
  assign bus.hready = ready;
  assign bus.hresp  = (state_q == ERR1 || state_q == ERR2);
  assign bus.hrdata = rdata_q;

  // BASE_ADDR is aligned to the window, so the window test is an upper-bit match.
  assign in_win = (bus.haddr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign idx_a  = bus.haddr[AW+1:2];

  // Alignment check and byte-lane enables for the address being offered.
  always_comb begin
    be_a  = 4'hF;
    fault = !in_win;
    case (bus.hsize)
      2'd0: be_a = 4'b0001 << bus.haddr[1:0];
      2'd1: begin
        be_a = bus.haddr[1] ? 4'b1100 : 4'b0011;
        if (bus.haddr[0]) fault = 1'b1;
      end
      2'd2: if (bus.haddr[1:0] != 2'b00) fault = 1'b1;
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    if (!ready) begin
      // Stall states advance unconditionally; RDW does its deferred read now.
      if (state_q == RDW) begin
        state_d = RD;
        rdata_d = mem[idx_q];
      end else begin
        state_d = ERR2;
      end
    end else if (!bus.htrans) begin
      state_d = IDLE;
    end else if (fault) begin
      state_d = ERR1;
    end else begin
      idx_d = idx_a;
      be_d  = be_a;
      if (bus.hwrite) begin
        state_d = WR;
      end else if (state_q == WR) begin
        // Port is busy with the write this edge; defer the read one cycle.
        state_d = RDW;
      end else begin
        state_d = RD;
        rdata_d = mem[idx_a];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Write commits at the edge ending WR; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == WR) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dsram_slave.sv
// Directed self-checking bench for dsram_slave.
module tb_dsram_slave;
  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dsram_slave_if bus();

  dsram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [1:0] sz, input logic wr);
    bus.htrans = 1'b1;
    bus.haddr  = a;
    bus.hsize  = sz;
    bus.hwrite = wr;
  endtask

  task automatic idle_bus();
    bus.htrans = 1'b0;
    bus.haddr  = 32'h0;
    bus.hsize  = 2'd0;
    bus.hwrite = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    bus.hprot  = 1'b1;
    bus.hwdata = 32'h0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (bus.hready !== 1'b1) begin errors++; $display("FAIL reset_hready got=%b want=1", bus.hready); end
    checks++; if (bus.hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp got=%b want=0", bus.hresp); end
    checks++; if (bus.hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%h want=0", bus.hrdata); end
  endtask

  task automatic test_word_rw();
    addr_phase(BASE, 2'd2, 1'b1);
    step();                          // WR data phase
    bus.hwdata = 32'hDEAD_BEEF;
    idle_bus();
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b0) begin errors++; $display("FAIL wr_phase hready=%b hresp=%b want 1/0", bus.hready, bus.hresp); end
    step();                          // IDLE
    addr_phase(BASE, 2'd2, 1'b0);
    step();                          // RD data phase
    idle_bus();
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b0) begin errors++; $display("FAIL rd_phase hready=%b hresp=%b want 1/0", bus.hready, bus.hresp); end
    checks++; if (bus.hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h want=deadbeef", bus.hrdata); end
    step();
  endtask

  task automatic test_byte_lanes();
    addr_phase(BASE + 32'd4, 2'd2, 1'b1);
    step();
    bus.hwdata = 32'h1122_3344;
    addr_phase(BASE + 32'd6, 2'd0, 1'b1);
    step();
    bus.hwdata = 32'h00AA_0000;
    addr_phase(BASE + 32'd4, 2'd1, 1'b1);
    step();
    bus.hwdata = 32'h0000_5566;
    idle_bus();
    checks++; if (bus.hready !== 1'b1) begin errors++; $display("FAIL b2b_write_hready got=%b want=1", bus.hready); end
    step();
    addr_phase(BASE + 32'd4, 2'd2, 1'b0);
    step();
    idle_bus();
    checks++; if (bus.hrdata !== 32'h11AA_5566) begin errors++; $display("FAIL lanes_data got=%h want=11aa5566", bus.hrdata); end
    step();
  endtask

  task automatic test_rdw();
    addr_phase(BASE + 32'd8, 2'd2, 1'b1);
    step();                          // WR
    bus.hwdata = 32'hCAFE_F00D;
    addr_phase(BASE + 32'd8, 2'd2, 1'b0);
    step();                          // RDW
    idle_bus();
    checks++; if (bus.hready !== 1'b0 || bus.hresp !== 1'b0) begin errors++; $display("FAIL rdw_stall hready=%b hresp=%b want 0/0", bus.hready, bus.hresp); end
    checks++; if (bus.hrdata !== 32'h11AA_5566) begin errors++; $display("FAIL rdw_hold got=%h want=11aa5566", bus.hrdata); end
    step();                          // RD
    checks++; if (bus.hready !== 1'b1) begin errors++; $display("FAIL rdw_done_hready got=%b want=1", bus.hready); end
    checks++; if (bus.hrdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rdw_data got=%h want=cafef00d", bus.hrdata); end
    step();
  endtask

  task automatic test_faults();
    logic [31:0] fa [4];
    logic [1:0]  fs [4];
    logic        fw [4];
    fa[0] = BASE + 32'd3;         fs[0] = 2'd2; fw[0] = 1'b0;
    fa[1] = BASE;                 fs[1] = 2'd3; fw[1] = 1'b1;
    fa[2] = BASE + 32'(4*DEPTH);  fs[2] = 2'd2; fw[2] = 1'b0;
    fa[3] = BASE + 32'd1;         fs[3] = 2'd1; fw[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_phase(fa[i], fs[i], fw[i]);
      step();                        // ERR1
      bus.hwdata = 32'hFFFF_FFFF;
      idle_bus();
      checks++; if (bus.hready !== 1'b0 || bus.hresp !== 1'b1) begin errors++; $display("FAIL err1_%0d hready=%b hresp=%b want 0/1", i, bus.hready, bus.hresp); end
      checks++; if (bus.hrdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_hold_%0d got=%h want=cafef00d", i, bus.hrdata); end
      step();                        // ERR2
      checks++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b1) begin errors++; $display("FAIL err2_%0d hready=%b hresp=%b want 1/1", i, bus.hready, bus.hresp); end
      // Last case: a read accepted in ERR2 proceeds normally and shows the array untouched.
      if (i == 3) addr_phase(BASE, 2'd2, 1'b0);
      step();
    end
    idle_bus();
    checks++; if (bus.hresp !== 1'b0 || bus.hready !== 1'b1) begin errors++; $display("FAIL err2_accept hready=%b hresp=%b want 1/0", bus.hready, bus.hresp); end
    checks++; if (bus.hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fault_nowrite got=%h want=deadbeef", bus.hrdata); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] top;
    top = BASE + 32'(4*(DEPTH-1));
    addr_phase(top, 2'd2, 1'b1);
    step();
    bus.hwdata = 32'h7777_8888;
    idle_bus();
    step();
    addr_phase(top, 2'd2, 1'b0);
    step();
    addr_phase(BASE, 2'd2, 1'b0);
    checks++; if (bus.hready !== 1'b1 || bus.hrdata !== 32'h7777_8888) begin errors++; $display("FAIL b2b_top hready=%b data=%h want 1/77778888", bus.hready, bus.hrdata); end
    step();
    idle_bus();
    checks++; if (bus.hready !== 1'b1 || bus.hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_base hready=%b data=%h want 1/deadbeef", bus.hready, bus.hrdata); end
    step();
  endtask

  task automatic test_reset_mid_write();
    addr_phase(BASE, 2'd2, 1'b1);
    step();                          // WR
    bus.hwdata = 32'h0BAD_0BAD;
    idle_bus();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b0) begin errors++; $display("FAIL rst_mid hready=%b hresp=%b want 1/0", bus.hready, bus.hresp); end
    checks++; if (bus.hrdata !== 32'h0) begin errors++; $display("FAIL rst_mid_hrdata got=%h want=0", bus.hrdata); end
    addr_phase(BASE, 2'd2, 1'b0);
    step();
    idle_bus();
    checks++; if (bus.hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_drop_write got=%h want=deadbeef", bus.hrdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_rdw();
    test_faults();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsram_slave.md
# dsram_slave

Single-port data SRAM slave on the processor data bus, directly downstream of the core's data bus interface. It accepts ahblite-like single-beat transfers, returns read data with zero wait states, and performs byte-lane writes during the write data phase. It inserts one wait state when a read address phase collides with a write data phase. Decode and alignment faults receive a two-cycle error response.

## Interface
- BASE_ADDR, 32'h2000_0000: byte base address of the SRAM window; aligned to window size.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- haddr  in  32  byte address (address phase).
- hprot  in  1  data/instruction indicator; ignored, both serviced.
- hsize  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (fault).
- hwrite  in  1  1 = write, 0 = read (address phase).
- hwdata  in  32  write data, lane-aligned, valid in write data phase.
- htrans  in  1  transfer valid (address phase).
- hrdata  out  32  full aligned word at haddr[31:2]; the master extracts lanes.
- hresp  out  1  1 = error response.
- hready  out  1  1 = current data phase completes this cycle and address phase is accepted.

## Operation
- Address phase accepted at a rising edge where htrans=1 and hready=1. The data phase occupies the following cycle(s).
- Fault check at acceptance. A transfer faults if any of the following holds:
  - haddr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - hsize=3.
  - hsize=1 and haddr[0]=1.
  - hsize=2 and haddr[1:0]≠0.
- Faulted transfers never touch the array.
- Word index = haddr[log2(DEPTH_WORDS)+1:2]. The array is a single-port register array with one access per cycle.
- Write byte enables:
  - byte: bit haddr[1:0].
  - half: bits {haddr[1],0}+{1,0}.
  - word: 4'hF.
  - Only enabled lanes of hwdata are written; other bytes are preserved.
- State machine, reset state IDLE:
  - IDLE: no data phase pending. hready=1, hresp=0.
  - RD: read data phase. hrdata = word registered at acceptance edge. hready=1.
  - WR: write data phase. hready=1. Array written at the edge ending WR using the registered address/enables and the current hwdata.
  - RDW: read accepted at the edge ending WR. The array port is busy, so the read is performed at the end of this cycle. hready=0, then go to RD.
  - ERR1: hready=0, hresp=1 → ERR2.
  - ERR2: hready=1, hresp=1; a transfer accepted here is processed normally.
- Transitions on each accepted address phase:
  - faulting → ERR1.
  - read → RD, or RDW if the current state is WR.
  - write → WR.
  - none → IDLE.
- Read after write to the same word: because of the RDW stall, hrdata returns the newly written value.
- hrdata holds its last value outside RD.

## Timing
- Reset (rst high at an edge): state=IDLE, hready=1, hresp=0, hrdata=0. Any pending write in WR is dropped. Array contents are unchanged, with no reset on the array.
- Reset mid-transfer takes effect at that edge. The next cycle is IDLE.
- Read latency: address edge → data valid in the next cycle, 0 wait states. With RDW, 1 wait state.
- Write: 0 wait states. Array updated at the edge ending the data phase.
- Error: 1 wait state (ERR1) + final cycle (ERR2). hresp=1 in both cycles.
- Back-to-back transfers are sustained every cycle, except read-after-write (+1 cycle).
- Wrap-around: the top word of the window is legal. BASE_ADDR+4*DEPTH_WORDS faults.

## Test plan
- Reset, then word write 32'hDEAD_BEEF @BASE, then read @BASE → write and read each complete with hready=1, no stall; read data phase hrdata=32'hDEAD_BEEF; hresp=0 throughout.
- Word 32'h1122_3344 @BASE+4, byte write 8'hAA lane 2 @BASE+6, half write 16'h5566 @BASE+4 → read returns 32'h11AA_5566.
- Write @BASE+8 then read @BASE+8 in the next cycle → RDW: hready=0 for one cycle, then hrdata=written value with hready=1.
- Read @BASE+3 with hsize=2, then hsize=3 @BASE, then read @BASE+4*DEPTH_WORDS → each gives ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); array unchanged.
- Back-to-back reads of last word and first word → one read per cycle, no wait states.
- rst asserted during a WR data phase → write not performed, outputs at reset values next cycle.
